// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store, holds it for LATENCY
// cycles, commits on entry to RESP and returns a one-cycle ack with registered load data.
module dmem_responder #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              req,
  input  logic              wmem,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              mem_stall
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              wmem_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mem [DEPTH];

  // The pipeline hold must drop in the ack cycle itself so the pipeline advances on that edge.
  assign mem_stall = req & ~ack;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // in this block samples pre-edge values regardless of statement order.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      ack     <= 1'b0;
      rdata   <= '0;
      wmem_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      // NOTE: the memory is a flop array cleared on reset, which discards any
      // uncommitted store; it therefore cannot map onto a plain RAM macro.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      ack <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            wmem_q  <= wmem;
            addr_q  <= addr;
            wdata_q <= wdata;
            if (LATENCY == 1) begin
              // The accept edge is also the commit edge, so use the live request fields.
              state <= RESP;
              ack   <= 1'b1;
              if (wmem) begin
                mem[addr] <= wdata;
              end else begin
                rdata <= mem[addr];
              end
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= RESP;
            ack   <= 1'b1;
            if (wmem_q) begin
              mem[addr_q] <= wdata_q;
            end else begin
              rdata <= mem[addr_q];
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three builds (LATENCY 2, 1, 4) driven by a directed vector
// table, a reset-abort sequence and random traffic checked against an array-based model.
module tb_dmem_responder;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int N_DUT  = 3;

  logic              clk;
  logic [N_DUT-1:0]  resetn;
  logic [N_DUT-1:0]  req;
  logic [N_DUT-1:0]  wmem;
  logic [N_DUT-1:0]  ack;
  logic [N_DUT-1:0]  mem_stall;
  logic [ADDR_W-1:0] addr  [N_DUT];
  logic [DATA_W-1:0] wdata [N_DUT];
  logic [DATA_W-1:0] rdata [N_DUT];

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] model_mem [N_DUT][DEPTH];
  logic [DATA_W-1:0] model_rd  [N_DUT];

  typedef struct {
    int          d;
    bit          wr;
    int          a;
    logic [31:0] wd;
    bit          hold;
    bit          scr;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tab[$];

  dmem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(2)) u_l2 (
    .Clock(clk), .Resetn(resetn[0]), .req(req[0]), .wmem(wmem[0]), .addr(addr[0]),
    .wdata(wdata[0]), .rdata(rdata[0]), .ack(ack[0]), .mem_stall(mem_stall[0]));

  dmem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(1)) u_l1 (
    .Clock(clk), .Resetn(resetn[1]), .req(req[1]), .wmem(wmem[1]), .addr(addr[1]),
    .wdata(wdata[1]), .rdata(rdata[1]), .ack(ack[1]), .mem_stall(mem_stall[1]));

  dmem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(4)) u_l4 (
    .Clock(clk), .Resetn(resetn[2]), .req(req[2]), .wmem(wmem[2]), .addr(addr[2]),
    .wdata(wdata[2]), .rdata(rdata[2]), .ack(ack[2]), .mem_stall(mem_stall[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_clear(input int d);
    for (int i = 0; i < DEPTH; i++) model_mem[d][i] = '0;
    model_rd[d] = '0;
  endtask

  // One transaction: req rises in cycle 0, ack expected exactly in cycle LATENCY.
  task automatic access(input int d, input bit wr, input int a, input logic [31:0] wd,
                        input bit hold, input bit scr, input string name,
                        output logic [31:0] got);
    int lat;
    int w;
    lat = lat_of(d);
    w = a % DEPTH;
    @(negedge clk);
    req[d]   = 1'b1;
    wmem[d]  = wr;
    addr[d]  = ADDR_W'(a);
    wdata[d] = wd;
    #1;
    check($sformatf("%s d%0d c0 stall", name, d), 32'(mem_stall[d]), 32'd1);
    check($sformatf("%s d%0d c0 ack", name, d), 32'(ack[d]), 32'd0);
    if (wr) model_mem[d][w] = wd;
    else    model_rd[d] = model_mem[d][w];
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (scr && k < lat) begin
        wmem[d]  = 1'($urandom);
        addr[d]  = ADDR_W'($urandom);
        wdata[d] = $urandom;
      end
      #1;
      if (k < lat) begin
        check($sformatf("%s d%0d c%0d stall", name, d, k), 32'(mem_stall[d]), 32'd1);
        check($sformatf("%s d%0d c%0d ack", name, d, k), 32'(ack[d]), 32'd0);
      end else begin
        check($sformatf("%s d%0d c%0d ack", name, d, k), 32'(ack[d]), 32'd1);
        check($sformatf("%s d%0d c%0d stall", name, d, k), 32'(mem_stall[d]), 32'd0);
        check($sformatf("%s d%0d c%0d rdata", name, d, k), rdata[d], model_rd[d]);
      end
    end
    got = rdata[d];
    if (!hold) begin
      @(negedge clk);
      req[d] = 1'b0;
      #1;
      check($sformatf("%s d%0d post ack", name, d), 32'(ack[d]), 32'd0);
      check($sformatf("%s d%0d post stall", name, d), 32'(mem_stall[d]), 32'd0);
      check($sformatf("%s d%0d post rdata", name, d), rdata[d], model_rd[d]);
    end
  endtask

  initial begin
    logic [31:0] got;
    int          d;
    int          prev_d;
    bit          held;

    resetn = '0;
    req    = '0;
    wmem   = '0;
    for (int i = 0; i < N_DUT; i++) begin
      addr[i]  = '0;
      wdata[i] = '0;
      model_clear(i);
    end

    // Reset hold with req low.
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < N_DUT; i++) begin
      check($sformatf("reset d%0d ack", i), 32'(ack[i]), 32'd0);
      check($sformatf("reset d%0d rdata", i), rdata[i], 32'd0);
      check($sformatf("reset d%0d stall", i), 32'(mem_stall[i]), 32'd0);
    end
    @(negedge clk);
    resetn = '1;

    tab.push_back('{0, 1'b0, 0,  32'h0,        1'b0, 1'b0, 32'h0,        "load0_after_reset"});
    tab.push_back('{0, 1'b0, 17, 32'h0,        1'b0, 1'b0, 32'h0,        "load17_after_reset"});
    tab.push_back('{0, 1'b1, 3,  32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        "store3"});
    tab.push_back('{0, 1'b0, 3,  32'h0,        1'b0, 1'b0, 32'hDEADBEEF, "load3"});
    tab.push_back('{0, 1'b1, 5,  32'h12345678, 1'b1, 1'b0, 32'hDEADBEEF, "store5_held"});
    tab.push_back('{0, 1'b0, 37, 32'h0,        1'b0, 1'b0, 32'h12345678, "load37_alias"});
    tab.push_back('{1, 1'b1, 9,  32'hCAFEF00D, 1'b0, 1'b0, 32'h0,        "l1_store9"});
    tab.push_back('{1, 1'b0, 9,  32'h0,        1'b0, 1'b0, 32'hCAFEF00D, "l1_load9"});
    tab.push_back('{2, 1'b1, 11, 32'h0BADF00D, 1'b0, 1'b1, 32'h0,        "l4_store11_scr"});
    tab.push_back('{2, 1'b0, 11, 32'h0,        1'b0, 1'b1, 32'h0BADF00D, "l4_load11_scr"});

    foreach (tab[i]) begin
      access(tab[i].d, tab[i].wr, tab[i].a, tab[i].wd, tab[i].hold, tab[i].scr, tab[i].name, got);
      check($sformatf("%s table rdata", tab[i].name), got, tab[i].exp);
    end

    // Reset pulsed during the WAIT cycle of a store discards it entirely.
    @(negedge clk);
    req[0]   = 1'b1;
    wmem[0]  = 1'b1;
    addr[0]  = 5'd7;
    wdata[0] = 32'hA5A5A5A5;
    @(negedge clk);
    #1;
    check("abort wait stall", 32'(mem_stall[0]), 32'd1);
    resetn[0] = 1'b0;
    req[0]    = 1'b0;
    #1;
    check("abort reset ack", 32'(ack[0]), 32'd0);
    check("abort reset rdata", rdata[0], 32'd0);
    check("abort reset stall", 32'(mem_stall[0]), 32'd0);
    model_clear(0);
    @(negedge clk);
    resetn[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("abort no ack c%0d", k), 32'(ack[0]), 32'd0);
    end
    access(0, 1'b0, 7, 32'h0, 1'b0, 1'b0, "abort_load7", got);
    check("abort_load7 value", got, 32'h0);
    access(0, 1'b0, 3, 32'h0, 1'b0, 1'b0, "abort_load3", got);
    check("abort_load3 value", got, 32'h0);

    // Random traffic against the model; a held req must continue on the same build.
    held   = 1'b0;
    prev_d = 0;
    for (int n = 0; n < 60; n++) begin
      bit hold;
      d = held ? prev_d : int'($urandom_range(0, N_DUT - 1));
      hold = ($urandom_range(0, 3) == 0) && (n != 59);
      access(d, 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 7)) + 32 * int'($urandom_range(0, 1)),
             $urandom, hold, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n), got);
      held   = hold;
      prev_d = d;
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
